// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin arbiter that shares one uart
// TX FIFO write port between NUM_REQ byte-stream requesters. A grant is held
// until the grantee's last byte, until MAX_BURST bytes have been sent, or
// until the grantee has been idle for IDLE_TIMEOUT cycles.
//
// Handshake: a requester byte moves when req_valid[i] & req_ready[i] are both
// high at a rising clk edge. A requester may raise valid at any time, but it
// must then hold req_data/req_last stable until ready. req_ready only depends
// on the registered grant and uart_tx_fifo_full, never on req_valid. Each
// accepted byte is written to the uart FIFO in the same cycle (uart_tx_start).
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 1024,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 grant_active,
  output logic [IDW-1:0]       grant_id,
  output logic                 uart_tx_start,
  output logic [7:0]           uart_tx_data_in,
  input  logic                 uart_tx_fifo_full
);

  localparam int BCW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int ITW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [ITW-1:0] idle_cnt_q, idle_cnt_d;

  // View of the current grantee's inputs.
  logic       g_valid;
  logic       g_last;
  logic [7:0] g_data;
  logic       accept;

  assign g_valid = req_valid[grant_id_q];
  assign g_last  = req_last[grant_id_q];
  assign g_data  = req_data[{grant_id_q, 3'b000} +: 8];
  assign accept  = (state_q == S_GRANT) && g_valid && !uart_tx_fifo_full;

  // Round-robin pick: first valid requester searching upward from last_grant+1.
  logic           pick_found;
  logic [IDW-1:0] pick_id;

  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
  end

  // State register together with grant bookkeeping and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      byte_cnt_q   <= '0;
      idle_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  // Next-state: arbitration in IDLE, counting and release decisions in GRANT.
  always_comb begin
    logic rel_last;
    logic rel_burst;
    logic rel_idle;
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    byte_cnt_d   = byte_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    rel_last     = 1'b0;
    rel_burst    = 1'b0;
    rel_idle     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d    = S_GRANT;
          grant_id_d = pick_id;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      S_GRANT: begin
        if (accept) begin
          idle_cnt_d = '0;
          if (byte_cnt_q != {BCW{1'b1}}) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (!g_valid && !uart_tx_fifo_full) begin
          if (idle_cnt_q != {ITW{1'b1}}) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
        // All release causes fold into one release; the counters restart
        // on the next grant, so nothing is double counted.
        rel_last  = accept && g_last;
        rel_burst = (MAX_BURST > 0) && accept &&
                    ((int'(byte_cnt_q) + 1) >= MAX_BURST);
        rel_idle  = (IDLE_TIMEOUT > 0) && !g_valid && !uart_tx_fifo_full &&
                    ((int'(idle_cnt_q) + 1) >= IDLE_TIMEOUT);
        if (rel_last || rel_burst || rel_idle) begin
          state_d      = S_IDLE;
          last_grant_d = grant_id_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: zero-cycle pass-through from the grantee to the uart FIFO.
  always_comb begin
    req_ready       = '0;
    uart_tx_start   = 1'b0;
    uart_tx_data_in = '0;
    grant_active    = (state_q == S_GRANT);
    grant_id        = grant_id_q;
    if (state_q == S_GRANT) begin
      req_ready[grant_id_q] = !uart_tx_fifo_full;
      uart_tx_start         = g_valid && !uart_tx_fifo_full;
      uart_tx_data_in       = g_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized packet
// traffic, checked by a scoreboard fed from a transaction-level arbitration
// model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int MAX_BURST    = 4;
  localparam int IDLE_TIMEOUT = 16;
  localparam int IDW          = 2;
  localparam int W            = IDW + 8;
  localparam int DEPTH        = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 grant_active;
  logic [IDW-1:0]       grant_id;
  logic                 uart_tx_start;
  logic [7:0]           uart_tx_data_in;
  logic                 uart_tx_fifo_full;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .MAX_BURST   (MAX_BURST),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_last         (req_last),
    .req_ready        (req_ready),
    .grant_active     (grant_active),
    .grant_id         (grant_id),
    .uart_tx_start    (uart_tx_start),
    .uart_tx_data_in  (uart_tx_data_in),
    .uart_tx_fifo_full(uart_tx_fifo_full)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // Per-requester byte sources: {last, data}.
  logic [8:0] src_mem [NUM_REQ][DEPTH];
  int         src_head[NUM_REQ];
  int         src_tail[NUM_REQ];
  int         m_last;

  bit ga_hist[4096];
  bit st_hist[4096];
  int first_gid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_src();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
  endtask

  // base < 0 gives random bytes, otherwise base, base+1, ...
  task automatic add_pkt(input int r, input int len, input int base, input bit term);
    logic [7:0] b;
    for (int j = 0; j < len; j++) begin
      b = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + j);
      src_mem[r][src_tail[r]] = {(term && (j == len - 1)), b};
      src_tail[r]++;
    end
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_head[i] < src_tail[i]) e = 1'b0;
    end
    return e;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_head[i] < src_tail[i]) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = src_mem[i][src_head[i]][7:0];
        req_last[i]         = src_mem[i][src_head[i]][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  // Reference model: with every requester holding valid while it has bytes
  // pending, the output stream is a sequence of grants in round-robin order;
  // each grant sends bytes until a last byte, MAX_BURST bytes, or the
  // requester running dry (which is what leads to an idle-timeout release).
  task automatic predict();
    int h[NUM_REQ];
    int found;
    int n;
    int idx;
    logic [8:0] e;
    for (int i = 0; i < NUM_REQ; i++) h[i] = src_head[i];
    forever begin
      found = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (m_last + k) % NUM_REQ;
        if (found < 0 && h[idx] < src_tail[idx]) found = idx;
      end
      if (found < 0) break;
      n = 0;
      do begin
        e = src_mem[found][h[found]];
        h[found]++;
        n++;
        exp_q.push_back({IDW'(found), e[7:0]});
      end while (!e[8] && n < MAX_BURST && h[found] < src_tail[found]);
      m_last = found;
    end
  endtask

  // Runs traffic from posedge+1 onward. full_mode: 0 never full, 1 random,
  // 2 full during cycles 3..52. stop_starts>0 returns after that many writes.
  task automatic run(input int max_cyc, input int full_mode, input int stop_starts);
    int c;
    int nst;
    bit done;
    logic [NUM_REQ-1:0] hs;
    c = 0;
    nst = 0;
    done = 1'b0;
    first_gid = -1;
    while (!done) begin
      drive_inputs();
      case (full_mode)
        1:       uart_tx_fifo_full = ($urandom_range(0, 3) == 0);
        2:       uart_tx_fifo_full = (c >= 3 && c < 53);
        default: uart_tx_fifo_full = 1'b0;
      endcase
      @(negedge clk);
      ga_hist[c] = grant_active;
      st_hist[c] = uart_tx_start;
      if (grant_active && first_gid < 0) first_gid = int'(grant_id);
      if (uart_tx_start) nst++;
      hs = req_valid & req_ready;
      if (stop_starts == 0 && all_empty() && !grant_active) done = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i]) src_head[i]++;
      end
      c++;
      if (stop_starts > 0 && nst >= stop_starts) done = 1'b1;
      if (!done && c >= max_cyc) begin
        checks++;
        failures++;
        $display("FAIL run_timeout cycles=%0d writes=%0d", c, nst);
        done = 1'b1;
      end
    end
    uart_tx_fifo_full = 1'b0;
    drive_inputs();
    if (stop_starts == 0) check("exp_drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_last = NUM_REQ - 1;
    clear_src();
    exp_q.delete();
    drive_inputs();
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] mon_exp;

  always @(negedge clk) begin
    if (!rst) begin
      if (uart_tx_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected actual=0x%0h expected=none", {grant_id, uart_tx_data_in});
        end else begin
          mon_exp = exp_q.pop_front();
          check("tx_byte", {grant_id, uart_tx_data_in}, mon_exp);
        end
      end
      if (uart_tx_fifo_full) begin
        check("ready_while_full", req_ready, 0);
        check("start_while_full", uart_tx_start, 0);
      end
      if (!grant_active) check("ready_when_idle", req_ready, 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int g;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    uart_tx_fifo_full = 1'b0;
    clear_src();
    m_last = NUM_REQ - 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_grant_active", grant_active, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_start", uart_tx_start, 0);
    check("rst_tx_data", uart_tx_data_in, 0);
    @(posedge clk);
    #1;

    // Single 3-byte packet from requester 0.
    add_pkt(0, 3, 'h41, 1'b1);
    predict();
    run(100, 0, 0);
    check("s1_no_grant_c0", ga_hist[0], 0);
    check("s1_grant_c1", ga_hist[1], 1);
    check("s1_first_gid", first_gid, 0);
    for (int c = 1; c <= 3; c++) check("s1_start", st_hist[c], 1);
    check("s1_release", ga_hist[4], 0);

    // All four requesters, 2-byte packets each.
    do_reset();
    for (int r = 0; r < NUM_REQ; r++) add_pkt(r, 2, 'h10 * (r + 1), 1'b1);
    predict();
    run(200, 0, 0);
    for (int k = 0; k < NUM_REQ; k++) begin
      check("s2_start_a", st_hist[1 + 3*k], 1);
      check("s2_start_b", st_hist[2 + 3*k], 1);
      check("s2_bubble", ga_hist[3 + 3*k], 0);
    end
    clear_src();
    add_pkt(0, 2, 'hA0, 1'b1);
    add_pkt(1, 2, 'hB0, 1'b1);
    predict();
    run(100, 0, 0);
    check("s2b_first_gid", first_gid, 0);

    // Burst limit: requester 2 sends 10 bytes while requester 1 waits.
    clear_src();
    add_pkt(2, 10, 'h01, 1'b1);
    add_pkt(1, 2, 'hC0, 1'b1);
    predict();
    run(200, 0, 0);
    check("s3_first_gid", first_gid, 2);
    check("s3_burst_4th", st_hist[4], 1);
    check("s3_burst_release", ga_hist[5], 0);
    check("s3_other_start", st_hist[6], 1);

    // FIFO full held 50 cycles mid-packet.
    clear_src();
    add_pkt(0, 5, 'h60, 1'b1);
    predict();
    run(300, 2, 0);
    n = 0;
    g = 0;
    for (int c = 3; c < 53; c++) begin
      n += int'(st_hist[c]);
      g += int'(ga_hist[c]);
    end
    check("s4_no_start_full", n, 0);
    check("s4_grant_held", g, 50);
    check("s4_resume", st_hist[53], 1);

    // Idle timeout: requester 1 sends one non-last byte then goes quiet.
    clear_src();
    add_pkt(1, 1, 'h71, 1'b0);
    add_pkt(2, 1, 'h72, 1'b1);
    predict();
    run(200, 0, 0);
    check("s5_first_gid", first_gid, 1);
    check("s5_held_16", ga_hist[17], 1);
    check("s5_released", ga_hist[18], 0);
    check("s5_next_grant", st_hist[19], 1);

    // Reset in the middle of a 5-byte packet after byte 2.
    clear_src();
    add_pkt(3, 5, 'h80, 1'b1);
    exp_q.push_back({2'd3, 8'h80});
    exp_q.push_back({2'd3, 8'h81});
    run(100, 0, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_src();
    m_last = NUM_REQ - 1;
    check("s6_flushed", exp_q.size(), 0);
    exp_q.delete();
    add_pkt(0, 1, 'h5A, 1'b1);
    add_pkt(3, 2, 'h90, 1'b1);
    predict();
    drive_inputs();
    @(negedge clk);
    check("s6_grant_active", grant_active, 0);
    check("s6_tx_start", uart_tx_start, 0);
    check("s6_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    run(100, 0, 0);
    check("s6_first_gid", first_gid, 0);

    // Randomized packets with random FIFO back-pressure.
    for (int it = 0; it < 8; it++) begin
      clear_src();
      for (int r = 0; r < NUM_REQ; r++) begin
        n = $urandom_range(0, 3);
        for (int p = 0; p < n; p++) add_pkt(r, $urandom_range(1, 6), -1, 1'b1);
      end
      predict();
      run(3000, 1, 0);
    end

    // ---------------- final report ----------------
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
